// File: rtl/shared_reg_arb_pkg.sv
// Shared definitions for the shared_reg_arb slice: FSM state encoding and
// parameter defaults for the requester count, data width and lock hold limit.
package shared_reg_arb_pkg;

  localparam int unsigned N_DEF        = 4;
  localparam int unsigned W_DEF        = 8;
  localparam int unsigned MAX_HOLD_DEF = 4;
  localparam int unsigned HOLD_W       = 4;  // wide enough for MAX_HOLD up to 15

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/shared_reg_arb_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports: req    - request vector
//        ptr    - index where the search starts (highest priority)
//        winner - index of the first set request at or after ptr (mod N)
//        valid  - at least one request is set
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          valid
);

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    winner = '0;
    valid  = |req;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % int'(N);
      if (req[idx]) winner = PW'(idx);
    end
  end

endmodule

// File: rtl/shared_reg_arb.sv
// shared_reg_arb: round-robin arbitrated write port onto one shared register.
// Ports: clk, rst_n (async active-low)
//        req[N]    - level-held write requests
//        wdata[N*W]- requester i data in slice [i*W +: W]
//        lock[N]   - keep the grant for further writes (SHARED_REG_ARB_LOCK_EN only)
//        gnt[N]    - one-hot write acknowledge, only while in GRANT
//        q, qbar   - shared register and its complement
//        busy      - FSM is not IDLE
// Build option: define SHARED_REG_ARB_LOCK_EN to enable the lock port and
// multi-write tenures of up to MAX_HOLD writes.
module shared_reg_arb
  import shared_reg_arb_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned W        = W_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
`ifdef SHARED_REG_ARB_LOCK_EN
  input  logic [N-1:0]   lock,
`endif
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic [W-1:0]   qbar,
  output logic           busy
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  state_t              state, state_d;
  logic [PW-1:0]       winner, winner_d;
  logic [PW-1:0]       ptr, ptr_d, ptr_next;
  logic [HOLD_W-1:0]   hold, hold_d;
  logic [PW-1:0]       pick;
  logic                pick_valid;
  logic                we;
  logic [N-1:0]        lock_w;

`ifdef SHARED_REG_ARB_LOCK_EN
  assign lock_w = lock;
`else
  assign lock_w = '0;
`endif

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

  assign ptr_next = (winner == PW'(N - 1)) ? '0 : winner + PW'(1);
  assign busy     = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      winner <= '0;
      ptr    <= '0;
      hold   <= '0;
    end else begin
      state  <= state_d;
      winner <= winner_d;
      ptr    <= ptr_d;
      hold   <= hold_d;
    end
  end

  // Next-state, grant and write-enable decode
  always_comb begin
    state_d  = state;
    winner_d = winner;
    ptr_d    = ptr;
    hold_d   = hold;
    we       = 1'b0;
    gnt      = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_d  = GRANT;
          winner_d = pick;
        end
      end
      GRANT: begin
        if (req[winner]) begin
          gnt[winner] = 1'b1;
          we          = 1'b1;
          if (lock_w[winner] && (hold < HOLD_W'(MAX_HOLD - 1))) begin
            hold_d = hold + HOLD_W'(1);
          end else begin
            state_d = IDLE;
            hold_d  = '0;
            ptr_d   = ptr_next;
          end
        end else begin
          // Withdrawn: a tenure that already wrote still hands priority on.
          state_d = IDLE;
          hold_d  = '0;
          if (hold != '0) ptr_d = ptr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared register; qbar kept as its own flop, reset to the complement of q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      qbar <= '1;
    end else if (we) begin
      q    <= wdata[winner*W +: W];
      qbar <= ~wdata[winner*W +: W];
    end
  end

endmodule

// File: doc/shared_reg_arb.md
SHARED_REG_ARB -- requirements
Module: shared_reg_arb

Interface
REQ-001 Parameter N, default 4: number of requesters, 2..8.
REQ-002 Parameter W, default 8: data width of the shared register.
REQ-003 Parameter MAX_HOLD, default 4: maximum consecutive locked writes per tenure, 1..15.
REQ-004 The clock SHALL be clk, input, 1 bit; all state changes occur on its rising edge.
REQ-005 The reset SHALL be rst_n, input, 1 bit, asynchronous and active-low.
REQ-006 req SHALL be an input of N bits: per-requester write request, level-held until granted.
REQ-007 wdata SHALL be an input of N*W bits: requester i data in slice [i*W +: W].
REQ-008 lock SHALL be an input of N bits: request to keep the grant for further writes; present only with SHARED_REG_ARB_LOCK_EN.
REQ-009 gnt SHALL be an output of N bits: one-hot write acknowledge.
REQ-010 q SHALL be an output of W bits: shared register value.
REQ-011 qbar SHALL be an output of W bits: bitwise complement of q.
REQ-012 busy SHALL be an output of 1 bit: high whenever the FSM is not IDLE.

Function
REQ-013 The FSM SHALL have two states, IDLE and GRANT.
REQ-014 IDLE: if req is nonzero, the block SHALL select a winner round-robin, starting the search at ptr, and enter GRANT; otherwise it stays in IDLE.
REQ-015 GRANT with req[winner]=1: gnt[winner]=1 for that cycle; q loads wdata[winner] and qbar loads its complement at the closing edge; ptr becomes (winner+1) mod N.
REQ-016 GRANT with req[winner]=0 (withdrawn): no gnt, no write, ptr unchanged, return to IDLE.
REQ-017 After a completed write without an active lock, the FSM SHALL return to IDLE, giving at most one write per two cycles.
REQ-018 Latency SHALL be 1 cycle from req sampled in IDLE to gnt, and 2 cycles from req to updated q.
REQ-019 gnt SHALL be zero outside GRANT and SHALL never have more than one bit set.
REQ-020 Requests arriving during GRANT SHALL be considered only at the next IDLE arbitration.
REQ-021 qbar SHALL equal ~q in every cycle, including during reset.

Reset
REQ-022 Asserting rst_n low SHALL force, immediately and independent of clk: q=0, qbar=all ones, gnt=0, busy=0, state=IDLE, ptr=0, hold counter=0.
REQ-023 Reset asserted mid-GRANT SHALL abort the write; q SHALL NOT take the pending wdata.
REQ-024 On the first edge after rst_n deasserts, the block SHALL arbitrate normally, with requester 0 highest priority.

Configuration
REQ-025 With SHARED_REG_ARB_LOCK_EN defined:
- when lock[winner]=1 at a completed write and the hold counter is below MAX_HOLD-1, the FSM SHALL stay in GRANT for the same winner and increment the counter;
- the counter SHALL clear when the FSM leaves GRANT;
- ptr SHALL advance only when the tenure ends.
REQ-026 Without the macro, the lock port SHALL be absent and behaviour SHALL be exactly REQ-013 to REQ-021.

Structure
REQ-027 A shared package shared_reg_arb_pkg SHALL hold the state enum (IDLE, GRANT) and the defaults for N, W and MAX_HOLD.
REQ-028 The round-robin winner selection SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs winner index and valid).
REQ-029 The q/qbar register SHALL stay inline in shared_reg_arb.

Verification
REQ-030 Reset: hold rst_n=0 -> q=0x00, qbar=0xFF, gnt=0, busy=0; release with req=0 -> all unchanged.
REQ-031 Single requester: req=0001, wdata0=0xA5 -> gnt=0001 one cycle later; next cycle q=0xA5, qbar=0x5A, busy=0.
REQ-032 Fairness: req=1111 held with distinct data -> grants in order 0001, 0010, 0100, 1000, 0001, each on alternate cycles.
REQ-033 Withdrawal: req=0100 for one cycle, then 0 -> no gnt, q unchanged, the following grant still starts search at the old ptr.
REQ-034 Mid-operation reset: pull rst_n low during GRANT -> gnt=0 immediately and q=0x00, not the pending data.
REQ-035 Lock (macro on, MAX_HOLD=4): req=0011, lock=0001 held -> gnt=0001 for 4 consecutive cycles, then IDLE, then gnt=0010.
